branch_redirect_ctrl: RTL and testbench
=======================================

Name: branch_redirect_ctrl

Overview:
- Sequences control-flow resolution for the 5-stage RV32I core.
- Consumes the resolved branch decision from EX and compares it with the fetch-time prediction.
- On a mismatch it drives a PC redirect to fetch through a valid/ready handshake, flushes IF/ID and ID/EX, and stalls EX until the redirect completes.
- Owns the bimodal branch history table (BHT) used by fetch for prediction, plus branch and mispredict statistics counters.

Parameters:
XLEN, 32, datapath/PC width
BHT_ENTRIES, 64, number of 2-bit counters; power of two, at least 2
FLUSH_CYCLES, 2, cycles flush stays asserted after redirect acceptance; at least 1

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
ex_valid  in  1  control-flow instruction present in EX this cycle
ex_is_branch  in  1  conditional branch (funct3-decoded)
ex_is_jump  in  1  JAL/JALR
ex_take_branch  in  1  resolved branch condition from EX compare logic
ex_pred_taken  in  1  prediction that fetch carried with this instruction
ex_pc  in  XLEN  PC of the EX instruction
ex_target  in  XLEN  computed branch/jump target
if_pc  in  XLEN  fetch PC for prediction lookup
if_pred_taken  out  1  BHT prediction for if_pc
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  XLEN  corrected next PC
redirect_ready  in  1  fetch accepts redirect
flush_if_id  out  1  squash IF/ID register
flush_id_ex  out  1  squash ID/EX register
stall_ex  out  1  hold EX/MEM advance
branch_count  out  32  resolved conditional branches, saturating
mispredict_count  out  32  mispredictions (branch and jump), saturating

Behaviour:
- States: IDLE, REDIRECT, DRAIN; 2-bit encoding, default branch returns to IDLE.
- Resolved direction: taken = ex_is_jump | (ex_is_branch & ex_take_branch). If both ex_is_jump and ex_is_branch are set, the jump wins.
- Mispredict = ex_valid & (taken != ex_pred_taken). Correct PC = taken ? ex_target : ex_pc + 4, modulo 2^XLEN.
- IDLE: a mispredict in cycle N causes the following in cycle N+1:
  - state becomes REDIRECT;
  - redirect_pc is registered;
  - redirect_valid, flush_if_id, flush_id_ex and stall_ex are all 1.
- REDIRECT:
  - redirect_valid and redirect_pc are held stable until redirect_ready is sampled high.
  - Flushes and stall stay 1.
  - Acceptance in cycle M: redirect_valid = 0 from M+1; state becomes DRAIN with drain counter = FLUSH_CYCLES-1.
- DRAIN:
  - flush_if_id, flush_id_ex and stall_ex stay 1; the counter decrements each cycle.
  - At 0, the next state is IDLE and all control outputs are 0.
- stall_ex = (state != IDLE). ex_valid is ignored outside IDLE because the instruction is being squashed: no BHT update, no counting.
- BHT:
  - Index = pc[log2(BHT_ENTRIES)+1:2].
  - Lookup is combinational: if_pred_taken = bht[idx(if_pc)][1].
  - Update: in IDLE with ex_valid & ex_is_branch, the entry at idx(ex_pc) increments (taken) or decrements (not taken), saturating at 3 and 0.
  - Jumps do not touch the BHT.
  - A lookup and an update to the same index in the same cycle return the pre-update value.
- Counters (IDLE only):
  - branch_count increments on ex_valid & ex_is_branch.
  - mispredict_count increments on each mispredict.
  - Both hold at 0xFFFF_FFFF.
- Reset (synchronous, rst_n = 0 at a clock edge, including mid-REDIRECT or mid-DRAIN):
  - state IDLE;
  - redirect_valid, flush_if_id, flush_id_ex and stall_ex all 0;
  - redirect_pc 0, both counters 0, all BHT entries 2'b01 (weakly not taken).
  - Any pending redirect is dropped.
- Outputs are registered, except if_pred_taken and stall_ex, which are decoded from state.

Decomposition:
- Shared core package: state enum type, the BHT counter width and reset value, and the PC increment constant of 4.
- Natural sub-module: bht_bimodal, containing the counter array, combinational read port, saturating update port and reset init. The FSM, redirect register and statistics counters stay in the top module.

Test Plan:
- Correct prediction: ex_valid = 1, branch, take = 1, pred = 1, pc = 0x100, target = 0x80 -> no redirect; stall_ex = 0; branch_count = 1; mispredict_count = 0; bht[0] goes 01 -> 10.
- Mispredict not-taken: pred = 1, take = 0, pc = 0x200 -> next cycle redirect_valid = 1, redirect_pc = 0x204, both flushes = 1. Holding redirect_ready = 0 for 3 cycles keeps redirect_pc stable; ready = 1 -> DRAIN for 2 cycles, then IDLE.
- JAL with pred = 0, pc = 0x40, target = 0x1000 -> redirect_pc = 0x1000; mispredict_count = 1; BHT unchanged. A second ex_valid during REDIRECT is ignored, so counts stay unchanged.
- BHT saturation and bypass: 4 taken updates on pc = 0x10 -> entry 11, and if_pred_taken(0x10) = 1. A same-cycle lookup during the first update reads 0.
- Wrap: pc = 0xFFFF_FFFC, not taken, pred = 1 -> redirect_pc = 0x0000_0000.
- rst_n = 0 during DRAIN -> next cycle all control outputs 0, counters 0, if_pred_taken = 0 for any if_pc.

Source files
------------

// File: rtl/branch_redirect_ctrl_pkg.sv
// branch_redirect_ctrl_pkg: shared types and constants for branch redirect control
package branch_redirect_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } state_t;
    localparam int CTR_W = 2;
    localparam logic [CTR_W-1:0] CTR_RESET = 2'b01;
    localparam int PC_INC = 4;
endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// branch_redirect_ctrl_if: EX resolution, fetch redirect handshake and pipeline control bundle
interface branch_redirect_ctrl_if #(parameter int XLEN = 32);
    logic            ex_valid;
    logic            ex_is_branch;
    logic            ex_is_jump;
    logic            ex_take_branch;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_target;
    logic [XLEN-1:0] if_pc;
    logic            if_pred_taken;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;
    logic            flush_if_id;
    logic            flush_id_ex;
    logic            stall_ex;
    logic [31:0]     branch_count;
    logic [31:0]     mispredict_count;
    modport master (
        output ex_valid, ex_is_branch, ex_is_jump, ex_take_branch, ex_pred_taken,
        output ex_pc, ex_target, if_pc, redirect_ready,
        input  if_pred_taken, redirect_valid, redirect_pc, flush_if_id, flush_id_ex,
        input  stall_ex, branch_count, mispredict_count
    );
    modport slave (
        input  ex_valid, ex_is_branch, ex_is_jump, ex_take_branch, ex_pred_taken,
        input  ex_pc, ex_target, if_pc, redirect_ready,
        output if_pred_taken, redirect_valid, redirect_pc, flush_if_id, flush_id_ex,
        output stall_ex, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_redirect_ctrl_bht_bimodal.sv
// bht_bimodal: 2-bit saturating counter table with combinational read and registered update
module bht_bimodal
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] rd_pc,
    output logic            rd_taken,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_pc,
    input  logic            wr_taken
);
    localparam int IW = $clog2(ENTRIES);

    logic [CTR_W-1:0] ctr [ENTRIES];
    logic [IW-1:0]    rd_idx, wr_idx;
    logic [CTR_W-1:0] cur, upd;
    logic             unused_pc_bits;

    assign rd_idx = rd_pc[IW+1:2];
    assign wr_idx = wr_pc[IW+1:2];
    assign unused_pc_bits = ^{rd_pc[XLEN-1:IW+2], rd_pc[1:0], wr_pc[XLEN-1:IW+2], wr_pc[1:0]};
    // read sees the pre-update value when it collides with a same-cycle write
    assign rd_taken = ctr[rd_idx][CTR_W-1];
    assign cur = ctr[wr_idx];
    assign upd = wr_taken ? (&cur ? cur : cur + 1'b1) : (|cur ? cur - 1'b1 : cur);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_RESET;
        end else if (wr_en) begin
            ctr[wr_idx] <= upd;
        end
    end
endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: mispredict detection, fetch redirect, flush/stall sequencing and branch stats
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BHT_ENTRIES  = 64,
    parameter int FLUSH_CYCLES = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    branch_redirect_ctrl_if.slave bus
);
    localparam int DW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;

    state_t          state, next;
    logic [DW-1:0]   drain, drain_next;
    logic            idle, taken, mispredict, br_upd;
    logic [XLEN-1:0] correct_pc;

    assign idle       = state == IDLE;
    assign taken      = bus.ex_is_jump | (bus.ex_is_branch & bus.ex_take_branch);
    // EX contents are being squashed whenever we are not idle
    assign mispredict = idle & bus.ex_valid & (taken != bus.ex_pred_taken);
    assign br_upd     = idle & bus.ex_valid & bus.ex_is_branch;
    assign correct_pc = taken ? bus.ex_target : bus.ex_pc + XLEN'(PC_INC);
    assign bus.stall_ex = !idle;

    bht_bimodal #(.XLEN(XLEN), .ENTRIES(BHT_ENTRIES)) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_pc    (bus.if_pc),
        .rd_taken (bus.if_pred_taken),
        .wr_en    (br_upd & ~bus.ex_is_jump),
        .wr_pc    (bus.ex_pc),
        .wr_taken (bus.ex_take_branch)
    );

    always_comb begin
        next       = state;
        drain_next = drain;
        case (state)
            IDLE:     next = mispredict ? REDIRECT : IDLE;
            REDIRECT: begin
                next       = bus.redirect_ready ? DRAIN : REDIRECT;
                drain_next = bus.redirect_ready ? DW'(FLUSH_CYCLES - 1) : drain;
            end
            DRAIN: begin
                next       = drain == '0 ? IDLE : DRAIN;
                drain_next = drain == '0 ? drain : drain - 1'b1;
            end
            default:  next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                <= IDLE;
            drain                <= '0;
            bus.redirect_valid   <= 1'b0;
            bus.redirect_pc      <= '0;
            bus.flush_if_id      <= 1'b0;
            bus.flush_id_ex      <= 1'b0;
            bus.branch_count     <= '0;
            bus.mispredict_count <= '0;
        end else begin
            state              <= next;
            drain              <= drain_next;
            bus.redirect_valid <= next == REDIRECT;
            bus.flush_if_id    <= next != IDLE;
            bus.flush_id_ex    <= next != IDLE;
            if (mispredict) bus.redirect_pc <= correct_pc;
            if (br_upd && !(&bus.branch_count)) bus.branch_count <= bus.branch_count + 1'b1;
            if (mispredict && !(&bus.mispredict_count)) bus.mispredict_count <= bus.mispredict_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed plus random stimulus against a behavioural redirect/BHT model
module tb_branch_redirect_ctrl;
    localparam int FC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_redirect_ctrl_if #(.XLEN(32)) bus();
    branch_redirect_ctrl #(.XLEN(32), .BHT_ENTRIES(64), .FLUSH_CYCLES(FC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          tests = 0;
    int          fails = 0;
    int          m_bht [64];
    logic [31:0] m_bc, m_mc, m_rpc;
    bit          m_pend;
    int          m_drain;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int idx(input logic [31:0] pc);
        return int'(pc[7:2]);
    endfunction

    function automatic bit busy();
        return m_pend || m_drain > 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 1;
        m_bc = 0; m_mc = 0; m_rpc = 0; m_pend = 0; m_drain = 0;
    endtask

    // one clock of the reference behaviour, using the inputs present at the edge
    task automatic model_edge();
        bit tk, mis;
        if (!rst_n) begin
            model_reset();
        end else if (!busy()) begin
            if (bus.ex_valid) begin
                tk  = bus.ex_is_jump || (bus.ex_is_branch && bus.ex_take_branch);
                mis = tk != bus.ex_pred_taken;
                if (bus.ex_is_branch && !bus.ex_is_jump) begin
                    if (bus.ex_take_branch && m_bht[idx(bus.ex_pc)] < 3) m_bht[idx(bus.ex_pc)]++;
                    if (!bus.ex_take_branch && m_bht[idx(bus.ex_pc)] > 0) m_bht[idx(bus.ex_pc)]--;
                end
                if (bus.ex_is_branch && m_bc != 32'hFFFF_FFFF) m_bc++;
                if (mis) begin
                    if (m_mc != 32'hFFFF_FFFF) m_mc++;
                    m_pend = 1;
                    m_rpc  = tk ? bus.ex_target : bus.ex_pc + 32'd4;
                end
            end
        end else if (m_pend) begin
            if (bus.redirect_ready) begin
                m_pend  = 0;
                m_drain = FC;
            end
        end else begin
            m_drain--;
        end
    endtask

    task automatic post_chk();
        chk("redirect_valid", bus.redirect_valid, m_pend);
        chk("redirect_pc", bus.redirect_pc, m_rpc);
        chk("flush_if_id", bus.flush_if_id, busy());
        chk("flush_id_ex", bus.flush_id_ex, busy());
        chk("stall_ex", bus.stall_ex, busy());
        chk("branch_count", bus.branch_count, m_bc);
        chk("mispredict_count", bus.mispredict_count, m_mc);
    endtask

    task automatic drive(input bit v, input bit b, input bit j, input bit t, input bit p,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic [31:0] ifpc, input bit rdy);
        bus.ex_valid = v; bus.ex_is_branch = b; bus.ex_is_jump = j;
        bus.ex_take_branch = t; bus.ex_pred_taken = p;
        bus.ex_pc = pc; bus.ex_target = tgt; bus.if_pc = ifpc; bus.redirect_ready = rdy;
    endtask

    task automatic cyc();
        #1;
        chk("if_pred_taken", bus.if_pred_taken, m_bht[idx(bus.if_pc)] >= 2);
        chk("stall_ex_pre", bus.stall_ex, busy());
        @(posedge clk);
        model_edge();
        #1;
        post_chk();
    endtask

    task automatic idle_cycles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 32'h100, rdy);
            cyc();
        end
    endtask

    initial begin
        int r;
        logic [31:0] pc;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        model_reset();
        #1;
        post_chk();
        rst_n = 1'b1;

        // correct taken prediction trains entry 0 towards taken
        drive(1, 1, 0, 1, 1, 32'h100, 32'h80, 32'h0, 0);
        cyc();
        chk("t1_branch_count", bus.branch_count, 32'd1);
        chk("t1_no_redirect", bus.redirect_valid, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 32'h100, 0);
        #1;
        chk("t1_bht0_taken", bus.if_pred_taken, 1'b1);

        // not-taken mispredict, redirect held across ready=0
        drive(1, 1, 0, 0, 1, 32'h200, 32'h900, 32'h0, 0);
        cyc();
        chk("t2_redirect_pc", bus.redirect_pc, 32'h204);
        chk("t2_flush", bus.flush_if_id, 1'b1);
        idle_cycles(3, 0);
        chk("t2_held_pc", bus.redirect_pc, 32'h204);
        idle_cycles(1, 1);
        chk("t2_drain_valid", bus.redirect_valid, 1'b0);
        idle_cycles(2, 0);
        chk("t2_back_idle", bus.stall_ex, 1'b0);

        // JAL mispredict, then a squashed EX instruction during REDIRECT
        drive(1, 0, 1, 0, 0, 32'h40, 32'h1000, 32'h40, 0);
        cyc();
        chk("t3_redirect_pc", bus.redirect_pc, 32'h1000);
        drive(1, 1, 0, 0, 1, 32'h300, 32'h0, 32'h40, 0);
        cyc();
        chk("t3_ignored_bc", bus.branch_count, 32'd2);
        chk("t3_ignored_mc", bus.mispredict_count, 32'd2);
        idle_cycles(1, 1);
        idle_cycles(2, 0);

        // saturate entry 4; first update reads the pre-update counter
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 1, (i >= 1), 32'h10, 32'h400, 32'h10, 0);
            if (i == 0) begin
                #1;
                chk("t4_bypass_old", bus.if_pred_taken, 1'b0);
            end
            cyc();
            if (busy()) begin
                idle_cycles(1, 1);
                idle_cycles(2, 0);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 32'h10, 0);
        #1;
        chk("t4_saturated", bus.if_pred_taken, 1'b1);

        // PC+4 wrap, then reset in the middle of DRAIN
        drive(1, 1, 0, 0, 1, 32'hFFFF_FFFC, 32'h0, 32'h0, 0);
        cyc();
        chk("t5_wrap_pc", bus.redirect_pc, 32'h0);
        idle_cycles(1, 1);
        rst_n = 1'b0;
        idle_cycles(1, 0);
        rst_n = 1'b1;
        chk("t6_rst_stall", bus.stall_ex, 1'b0);
        chk("t6_rst_bc", bus.branch_count, 32'd0);
        for (int i = 0; i < 8; i++) begin
            bus.if_pc = 32'h10 + i * 4;
            #1;
            chk("t6_rst_bht", bus.if_pred_taken, 1'b0);
        end

        // random traffic with aliasing PCs and occasional resets
        for (int n = 0; n < 800; n++) begin
            r  = int'($urandom_range(0, 2));
            pc = ($urandom_range(0, 15) << 2) | ($urandom_range(0, 1) ? 32'hFFFF_FF00 : 32'h0);
            drive($urandom_range(0, 1), r == 0, r == 1, $urandom_range(0, 1), $urandom_range(0, 1),
                  pc, $urandom, $urandom_range(0, 15) << 2, $urandom_range(0, 1));
            rst_n = $urandom_range(0, 99) != 0;
            cyc();
        end
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
